// File: rtl/mem_io_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_io_bridge_if: mesh io bus plus external outbound/inbound streams.      |
// | Optional lb_mode signal present when MEM_IO_LOOPBACK_EN is defined.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_io_bridge_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IO_PORTS   = 8,
  parameter int PORT_WIDTH = 3
);
  logic [IO_PORTS-1:0]            io_active_out;
  logic [IO_PORTS*DATA_WIDTH-1:0] io_data_out;
  logic [IO_PORTS-1:0]            io_active_in;
  logic [IO_PORTS*DATA_WIDTH-1:0] io_data_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [PORT_WIDTH-1:0]          out_port;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [PORT_WIDTH-1:0]          in_port;
  logic [DATA_WIDTH-1:0]          in_data;
  logic [IO_PORTS-1:0]            drop;
`ifdef MEM_IO_LOOPBACK_EN
  logic                           lb_mode;
`endif

  modport slave (
`ifdef MEM_IO_LOOPBACK_EN
    input  lb_mode,
`endif
    input  io_active_out, io_data_out, out_ready, in_valid, in_port, in_data,
    output io_active_in, io_data_in, out_valid, out_port, out_data, in_ready, drop
  );

  modport master (
`ifdef MEM_IO_LOOPBACK_EN
    output lb_mode,
`endif
    output io_active_out, io_data_out, out_ready, in_valid, in_port, in_data,
    input  io_active_in, io_data_in, out_valid, out_port, out_data, in_ready, drop
  );
endinterface
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_io_bridge: mesh io ports <-> one outbound and one inbound stream.      |
// | MEM_IO_LOOPBACK_EN adds lb_mode, re-injecting emitted words inbound.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_io_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int IO_PORTS   = 8,
  parameter int PORT_WIDTH = 3
) (
  input wire             clk,
  input wire             rst,
  mem_io_bridge_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IO_PORTS-1:0]   pend_q, pend_d;
  logic [IO_PORTS-1:0]   drop_q, drop_d;
  logic [DATA_WIDTH-1:0] slot_q [IO_PORTS];
  logic [DATA_WIDTH-1:0] slot_d [IO_PORTS];
  logic [PORT_WIDTH-1:0] rr_q, rr_d;
  logic [PORT_WIDTH-1:0] out_port_q, out_port_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IO_PORTS-1:0]   inj_act_q, inj_act_d;
  logic [DATA_WIDTH-1:0] inj_data_q, inj_data_d;

  logic                  hi_found, lo_found;
  logic [PORT_WIDTH-1:0] hi_idx, lo_idx, pick_idx;
  logic                  load_en, out_hs, in_ready_d;
  logic                  src_valid;
  logic [PORT_WIDTH-1:0] src_port;
  logic [DATA_WIDTH-1:0] src_data;

  // Round-robin pick: lowest pending port >= rr_q, else lowest pending overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int p = IO_PORTS - 1; p >= 0; p--) begin
      if (pend_q[p]) begin
        if (PORT_WIDTH'(p) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = PORT_WIDTH'(p);
        end
        lo_found = 1'b1;
        lo_idx   = PORT_WIDTH'(p);
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    slot_d     = slot_q;
    rr_d       = rr_q;
    out_port_d = out_port_q;
    out_data_d = out_data_q;
    out_hs     = (state_q == S_BUSY) && bus.out_ready;
    load_en    = lo_found && ((state_q == S_IDLE) || bus.out_ready);

    if (load_en) begin
      state_d          = S_BUSY;
      out_port_d       = pick_idx;
      out_data_d       = slot_q[pick_idx];
      pend_d[pick_idx] = 1'b0;
      rr_d = (pick_idx == PORT_WIDTH'(IO_PORTS - 1)) ? '0 : pick_idx + PORT_WIDTH'(1);
    end else if (out_hs) begin
      state_d = S_IDLE;
    end

    // A capture overrides the pend clear above; the old slot value already left.
    for (int p = 0; p < IO_PORTS; p++) begin
      if (bus.io_active_out[p]) begin
        slot_d[p] = bus.io_data_out[p*DATA_WIDTH +: DATA_WIDTH];
        if (pend_q[p] && !(load_en && (pick_idx == PORT_WIDTH'(p)))) begin
          drop_d[p] = 1'b1;
        end
        pend_d[p] = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef MEM_IO_LOOPBACK_EN
    in_ready_d = !rst && !bus.lb_mode;
`else
    in_ready_d = !rst;
`endif
    src_valid = bus.in_valid && in_ready_d;
    src_port  = bus.in_port;
    src_data  = bus.in_data;
`ifdef MEM_IO_LOOPBACK_EN
    if (bus.lb_mode) begin
      src_valid = out_hs;
      src_port  = out_port_q;
      src_data  = out_data_q;
    end
`endif
    // Out-of-range ports match no index and are silently discarded.
    inj_act_d = '0;
    for (int p = 0; p < IO_PORTS; p++) begin
      if (src_valid && (src_port == PORT_WIDTH'(p))) begin
        inj_act_d[p] = 1'b1;
      end
    end
    inj_data_d = src_valid ? src_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      drop_q     <= '0;
      rr_q       <= '0;
      out_port_q <= '0;
      out_data_q <= '0;
      inj_act_q  <= '0;
      inj_data_q <= '0;
      for (int p = 0; p < IO_PORTS; p++) begin
        slot_q[p] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      rr_q       <= rr_d;
      out_port_q <= out_port_d;
      out_data_q <= out_data_d;
      inj_act_q  <= inj_act_d;
      inj_data_q <= inj_data_d;
      slot_q     <= slot_d;
    end
  end

  generate
    for (genvar p = 0; p < IO_PORTS; p++) begin : g_inj
      assign bus.io_data_in[p*DATA_WIDTH +: DATA_WIDTH] = inj_act_q[p] ? inj_data_q : '0;
    end
  endgenerate

  assign bus.io_active_in = inj_act_q;
  assign bus.out_valid    = (state_q == S_BUSY);
  assign bus.out_port     = out_port_q;
  assign bus.out_data     = out_data_q;
  assign bus.in_ready     = in_ready_d;
  assign bus.drop         = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_io_bridge: directed self-checking bench for mem_io_bridge.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_io_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_io_bridge_if #(.DATA_WIDTH(16), .IO_PORTS(8), .PORT_WIDTH(3)) bus ();
  mem_io_bridge_if #(.DATA_WIDTH(16), .IO_PORTS(6), .PORT_WIDTH(3)) b6 ();

  mem_io_bridge #(.DATA_WIDTH(16), .IO_PORTS(8), .PORT_WIDTH(3)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // Six-port instance so that a 3-bit in_port can address a non-existent port.
  mem_io_bridge #(.DATA_WIDTH(16), .IO_PORTS(6), .PORT_WIDTH(3)) u_dut6 (
    .clk(clk), .rst(rst), .bus(b6.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int p, input logic [15:0] d);
    bus.io_active_out[p]         = 1'b1;
    bus.io_data_out[p*16 +: 16]  = d;
  endtask

  task automatic wr_clr();
    bus.io_active_out = '0;
    bus.io_data_out   = '0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] port, input logic [15:0] data);
    chk({tag, ".valid"}, 128'(bus.out_valid), 128'(1));
    chk({tag, ".port"},  128'(bus.out_port),  128'(port));
    chk({tag, ".data"},  128'(bus.out_data),  128'(data));
  endtask

  initial begin
    bus.io_active_out = '0;
    bus.io_data_out   = '0;
    bus.out_ready     = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_port       = '0;
    bus.in_data       = '0;
    b6.io_active_out  = '0;
    b6.io_data_out    = '0;
    b6.out_ready      = 1'b0;
    b6.in_valid       = 1'b0;
    b6.in_port        = '0;
    b6.in_data        = '0;
`ifdef MEM_IO_LOOPBACK_EN
    bus.lb_mode       = 1'b0;
    b6.lb_mode        = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    chk("rst.out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst.in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst.drop", 128'(bus.drop), 128'(0));
    chk("rst.io_active_in", 128'(bus.io_active_in), 128'(0));
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("run.in_ready", 128'(bus.in_ready), 128'(1));

    // Single word on port 2
    wr(2, 16'h1234);
    tick();
    wr_clr();
    tick();
    chk_out("t1", 3'd2, 16'h1234);
    chk("t1.drop", 128'(bus.drop), 128'(0));
    tick();
    chk("t1.idle", 128'(bus.out_valid), 128'(0));

    // Move rr_ptr to 4 via port 3, then ports 0/3/7 together
    wr(3, 16'h0003);
    tick();
    wr_clr();
    tick();
    chk_out("t2.pre", 3'd3, 16'h0003);
    tick();
    wr(0, 16'h1000);
    wr(3, 16'h3000);
    wr(7, 16'h7000);
    tick();
    wr_clr();
    tick();
    chk_out("t2.w0", 3'd7, 16'h7000);
    tick();
    chk_out("t2.w1", 3'd0, 16'h1000);
    tick();
    chk_out("t2.w2", 3'd3, 16'h3000);
    tick();
    chk("t2.idle", 128'(bus.out_valid), 128'(0));

    // Backpressure and overwrite on port 5
    bus.out_ready = 1'b0;
    wr(1, 16'h1111);
    tick();
    wr_clr();
    tick();
    wr(5, 16'hAAAA);
    tick();
    wr_clr();
    wr(5, 16'hBBBB);
    tick();
    wr_clr();
    chk("t3.drop", 128'(bus.drop), 128'(8'h20));
    chk_out("t3.hold", 3'd1, 16'h1111);
    bus.out_ready = 1'b1;
    tick();
    chk_out("t3.new", 3'd5, 16'hBBBB);
    tick();
    chk("t3.idle", 128'(bus.out_valid), 128'(0));
    chk("t3.sticky", 128'(bus.drop), 128'(8'h20));

    // Inbound pulse; out-of-range port on the six-port instance
    bus.in_valid = 1'b1;
    bus.in_port  = 3'd1;
    bus.in_data  = 16'h00FF;
    b6.in_valid  = 1'b1;
    b6.in_port   = 3'd7;
    b6.in_data   = 16'hCAFE;
    tick();
    bus.in_valid = 1'b0;
    b6.in_port   = 3'd5;
    chk("t4.act", 128'(bus.io_active_in), 128'(8'b0000_0010));
    chk("t4.data", 128'(bus.io_data_in), {112'd0, 16'h00FF} << 16);
    chk("t4.oor.act", 128'(b6.io_active_in), 128'(0));
    chk("t4.oor.data", 128'(b6.io_data_in), 128'(0));
    tick();
    b6.in_valid = 1'b0;
    chk("t4.once", 128'(bus.io_active_in), 128'(0));
    chk("t4.p5.act", 128'(b6.io_active_in), 128'(6'b10_0000));
    chk("t4.p5.data", 128'(b6.io_data_in), {112'd0, 16'hCAFE} << 80);

    // Reset while busy with three ports pending
    bus.out_ready = 1'b0;
    wr(2, 16'h0222);
    wr(4, 16'h0444);
    wr(6, 16'h0666);
    tick();
    wr_clr();
    tick();
    wr(0, 16'h0111);
    tick();
    wr_clr();
    chk("t5.busy", 128'(bus.out_valid), 128'(1));
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_port  = 3'd3;
    tick();
    chk("t5.valid", 128'(bus.out_valid), 128'(0));
    chk("t5.drop", 128'(bus.drop), 128'(0));
    chk("t5.in_ready", 128'(bus.in_ready), 128'(0));
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t5.noinj", 128'(bus.io_active_in), 128'(0));
    chk("t5.post0", 128'(bus.out_valid), 128'(0));
    tick();
    chk("t5.post1", 128'(bus.out_valid), 128'(0));
    tick();
    chk("t5.post2", 128'(bus.out_valid), 128'(0));

    // Same port loaded and recaptured in one cycle
    wr(2, 16'h0A0A);
    tick();
    wr_clr();
    wr(2, 16'h0B0B);
    tick();
    wr_clr();
    chk_out("t7.old", 3'd2, 16'h0A0A);
    chk("t7.nodrop", 128'(bus.drop), 128'(0));
    tick();
    chk_out("t7.new", 3'd2, 16'h0B0B);
    tick();
    chk("t7.idle", 128'(bus.out_valid), 128'(0));

`ifdef MEM_IO_LOOPBACK_EN
    bus.lb_mode = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_port  = 3'd6;
    #1;
    chk("t6.in_ready", 128'(bus.in_ready), 128'(0));
    wr(4, 16'h5A5A);
    tick();
    wr_clr();
    chk("t6.ext_ignored", 128'(bus.io_active_in), 128'(0));
    tick();
    chk_out("t6.out", 3'd4, 16'h5A5A);
    tick();
    chk("t6.act", 128'(bus.io_active_in), 128'(8'h10));
    chk("t6.data", 128'(bus.io_data_in), {112'd0, 16'h5A5A} << 64);
    tick();
    chk("t6.once", 128'(bus.io_active_in), 128'(0));
    bus.in_valid = 1'b0;
    bus.lb_mode  = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
